// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared definitions for the datapath sequencer.
//   - instruction width and field bit positions
//   - instruction class codes
//   - FSM state enum (STEP_WAIT exists only with DP_SEQ_SINGLE_STEP_EN)
//   - dp_ctrl_t: the datapath control bundle produced by the decoder
package dp_seq_pkg;

  localparam int INSTR_W = 20;

  localparam int CLS_HI = 19;
  localparam int CLS_LO = 16;
  localparam int AOP_HI = 15;
  localparam int AOP_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RA_HI  = 7;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_ALU  = 4'h1;
  localparam logic [3:0] CLS_CMP  = 4'h2;
  localparam logic [3:0] CLS_LDI  = 4'h3;
  localparam logic [3:0] CLS_JMP  = 4'h4;
  localparam logic [3:0] CLS_JZ   = 4'h5;
  localparam logic [3:0] CLS_JC   = 4'h6;
  localparam logic [3:0] CLS_OUT  = 4'h7;
  localparam logic [3:0] CLS_HALT = 4'hF;

`ifdef DP_SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_STEP_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_t;
`endif

  typedef struct packed {
    logic       alu_en;
    logic [3:0] alu_opcode;
    logic [7:0] user_write_data;
    logic [3:0] write_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic       write_en;
  } dp_ctrl_t;

endpackage

// File: rtl/dp_seq_decode.sv
// dp_seq_decode: combinational instruction decoder.
// Ports:
//   ir          in   INSTR_W  latched instruction
//   flag_z/c    in   1        registered flags (for conditional branches)
//   ctrl        out  bundle   datapath controls for this instruction
//   is_branch   out  1        branch taken (JMP, or JZ/JC with flag set)
//   is_halt     out  1        HALT class
//   is_out      out  1        OUT class
//   is_flag_upd out  1        ALU/CMP: flags latch on the EXEC edge
//   is_illegal  out  1        undefined class 8..E
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  input  logic               flag_z,
  input  logic               flag_c,
  output dp_ctrl_t           ctrl,
  output logic               is_branch,
  output logic               is_halt,
  output logic               is_out,
  output logic               is_flag_upd,
  output logic               is_illegal
);

  logic [3:0] cls, aop, rd, ra, rb;
  logic [7:0] imm;

  assign cls = ir[CLS_HI:CLS_LO];
  assign aop = ir[AOP_HI:AOP_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign ra  = ir[RA_HI:RA_LO];
  assign rb  = ir[RB_HI:RB_LO];
  assign imm = ir[IMM_HI:IMM_LO];

  always_comb begin
    ctrl        = '0;
    is_branch   = 1'b0;
    is_halt     = 1'b0;
    is_out      = 1'b0;
    is_flag_upd = 1'b0;
    is_illegal  = 1'b0;
    case (cls)
      CLS_NOP: ;
      CLS_ALU: begin
        ctrl.alu_en     = 1'b1;
        ctrl.alu_opcode = aop;
        ctrl.write_addr = rd;
        ctrl.ra_addr    = ra;
        ctrl.rb_addr    = rb;
        ctrl.write_en   = 1'b1;
        is_flag_upd     = 1'b1;
      end
      CLS_CMP: begin
        ctrl.alu_en     = 1'b1;
        ctrl.alu_opcode = aop;
        ctrl.ra_addr    = ra;
        ctrl.rb_addr    = rb;
        is_flag_upd     = 1'b1;
      end
      CLS_LDI: begin
        ctrl.write_addr      = rd;
        ctrl.user_write_data = imm;
        ctrl.write_en        = 1'b1;
      end
      CLS_JMP: is_branch = 1'b1;
      CLS_JZ:  is_branch = flag_z;
      CLS_JC:  is_branch = flag_c;
      CLS_OUT: begin
        ctrl.ra_addr = ra;
        is_out       = 1'b1;
      end
      CLS_HALT: is_halt = 1'b1;
      default:  is_illegal = 1'b1;  // classes 8..E
    endcase
  end

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: fetch/decode/execute controller for the 8-bit, 16-register
// ALU datapath. Three cycles per instruction (FETCH, DECODE, EXEC).
// Optional feature macro: DP_SEQ_SINGLE_STEP_EN (adds step_mode/step and
// the STEP_WAIT state).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       level, sampled in IDLE/HALT
//   step_mode, step             single-step controls (macro builds only)
//   imem_addr / imem_data       sync instruction ROM, 1-cycle latency
//   alu_en, alu_opcode, user_write_data, write_addr, ra_addr, rb_addr,
//   write_en                    datapath controls, zero outside EXEC
//   read_a, alu_zero, alu_carry datapath feedback
//   out_data, out_valid         OUT result and its one-cycle pulse
//   busy, halted, illegal       status
//   flag_z, flag_c              registered ALU flags
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef DP_SEQ_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               alu_en,
  output logic [3:0]         alu_opcode,
  output logic [7:0]         user_write_data,
  output logic [3:0]         write_addr,
  output logic [3:0]         ra_addr,
  output logic [3:0]         rb_addr,
  output logic               write_en,
  input  logic [7:0]         read_a,
  input  logic               alu_zero,
  input  logic               alu_carry,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               flag_z,
  output logic               flag_c
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;

  dp_ctrl_t dec_ctrl, ctrl;
  logic     dec_branch, dec_halt, dec_out, dec_flag_upd, dec_illegal;

  dp_seq_decode u_decode (
    .ir          (ir),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .ctrl        (dec_ctrl),
    .is_branch   (dec_branch),
    .is_halt     (dec_halt),
    .is_out      (dec_out),
    .is_flag_upd (dec_flag_upd),
    .is_illegal  (dec_illegal)
  );

  // Next state and gated controls. Controls derive from state so an async
  // reset drops write_en in the same instant.
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE:       state_nxt = S_EXEC;
      S_EXEC: begin
        ctrl = dec_ctrl;
        if (dec_halt || dec_illegal) state_nxt = S_HALT;
`ifdef DP_SEQ_SINGLE_STEP_EN
        else if (step_mode)          state_nxt = S_STEP_WAIT;
`endif
        else                         state_nxt = S_FETCH;
      end
`ifdef DP_SEQ_SINGLE_STEP_EN
      S_STEP_WAIT: if (step) state_nxt = S_FETCH;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      illegal   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc      <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            illegal <= 1'b0;
          end
        end
        S_DECODE: begin
          ir <= imem_data;
          pc <= pc + PC_ONE;  // natural wrap at 2^PC_W
        end
        S_EXEC: begin
          if (dec_flag_upd) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
          end
          // taken branch overrides the increment done in DECODE
          if (dec_branch) pc <= ir[PC_W-1:0];
          if (dec_out) begin
            out_data  <= read_a;
            out_valid <= 1'b1;
          end
          if (dec_illegal) illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr       = pc;
  assign alu_en          = ctrl.alu_en;
  assign alu_opcode      = ctrl.alu_opcode;
  assign user_write_data = ctrl.user_write_data;
  assign write_addr      = ctrl.write_addr;
  assign ra_addr         = ctrl.ra_addr;
  assign rb_addr         = ctrl.rb_addr;
  assign write_en        = ctrl.write_en;

  assign halted = (state == S_HALT);
  assign busy   = (state != S_HALT) && (state != S_IDLE);

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed bench with a ROM, register file and ALU model.
// ALU model: op0 add (carry out), op1 sub (carry = borrow), op2 and.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef DP_SEQ_SINGLE_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
`endif
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic        alu_en, write_en, out_valid, busy, halted, illegal;
  logic        flag_z, flag_c, alu_zero, alu_carry;
  logic [3:0]  alu_opcode, write_addr, ra_addr, rb_addr;
  logic [7:0]  user_write_data, read_a, read_b, out_data, alu_res;

  logic [19:0] rom [256];
  logic [7:0]  rf [16];
  logic        rf_clr = 1'b0;
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dp_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DP_SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .user_write_data(user_write_data),
    .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .write_en(write_en), .read_a(read_a), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .halted(halted),
    .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c)
  );

  // datapath and memory models
  always @(posedge clk) imem_data <= rom[imem_addr];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (write_en) begin
      rf[write_addr] <= alu_en ? alu_res : user_write_data;
    end
  end

  always @(posedge clk) if (write_en) wr_cnt <= wr_cnt + 1;

  assign read_a = rf[ra_addr];
  assign read_b = rf[rb_addr];

  always_comb begin
    alu_carry = 1'b0;
    alu_res   = read_a;
    case (alu_opcode)
      4'h0: {alu_carry, alu_res} = {1'b0, read_a} + {1'b0, read_b};
      4'h1: {alu_carry, alu_res} = {1'b0, read_a} - {1'b0, read_b};
      4'h2: alu_res = read_a & read_b;
      default: ;
    endcase
    alu_zero = (alu_res == 8'h00);
  end

  typedef struct {
    logic [5:0][19:0] prog;
    int               cyc;
    logic [3:0]       reg_i;
    logic [7:0]       reg_v;
    logic             z, c, ill;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 20'hF0000;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    rf_clr = 1'b1;
    tick(2);
    rf_clr = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 200) begin
      tick(1);
      n++;
    end
    if (!halted) check("halt_timeout", 32'(halted), 32'd1);
  endtask

  initial begin
    int n, hi, first, wb;
    vec_t v;

    // program, cycles, reg, value, z, c, illegal
    vecs[0] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'h10312, 20'h302FB, 20'h30105}, 12, 4'd3, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'h11312, 20'h30205, 20'h30103}, 12, 4'd3, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'h12312, 20'h302F0, 20'h3010F}, 12, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'h21412, 20'h30207, 20'h30107}, 12, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'h30555, 20'h305AA, 20'h40002},  9, 4'd5, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{{20'hF0000, 20'h30711, 20'h60005, 20'h10312, 20'h30201, 20'h301FF}, 15, 4'd7, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{{20'hF0000, 20'h30722, 20'h50005, 20'h10312, 20'h30201, 20'h30101}, 18, 4'd7, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'hF0000, 20'h80112, 20'h30101},  6, 4'd1, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'hF0000, 20'hF0000, 20'hE0000},  3, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{{20'hF0000, 20'hF0000, 20'hF0000, 20'hF0000, 20'h30A3C, 20'h00000},  9, 4'd10, 8'h3C, 1'b0, 1'b0, 1'b0};

    rom_clear();
    do_reset();

    // reset state
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_flags", 32'({flag_z, flag_c}), 32'd0);

    // table-driven programs
    for (int k = 0; k < 10; k++) begin
      v = vecs[k];
      rom_clear();
      for (int i = 0; i < 6; i++) rom[i] = v.prog[i];
      do_reset();
      pulse_start();
      wait_halt(n);
      check($sformatf("v%0d_cycles", k), 32'(n), 32'(v.cyc));
      check($sformatf("v%0d_halted", k), 32'(halted), 32'd1);
      check($sformatf("v%0d_reg", k), 32'(rf[v.reg_i]), 32'(v.reg_v));
      check($sformatf("v%0d_flag_z", k), 32'(flag_z), 32'(v.z));
      check($sformatf("v%0d_flag_c", k), 32'(flag_c), 32'(v.c));
      check($sformatf("v%0d_illegal", k), 32'(illegal), 32'(v.ill));
    end

    // JZ not taken: next fetch at pc+1
    rom_clear();
    rom[0] = 20'h50010;
    do_reset();
    pulse_start();
    tick(3);
    check("jz_nt_addr", 32'(imem_addr), 32'h01);

    // JZ taken after ADD producing zero
    rom_clear();
    rom[0] = 20'h30100; rom[1] = 20'h10211; rom[2] = 20'h50010;
    do_reset();
    pulse_start();
    tick(9);
    check("jz_t_flag_z", 32'(flag_z), 32'd1);
    check("jz_t_addr", 32'(imem_addr), 32'h10);

    // OUT: one pulse, six cycles after start
    rom_clear();
    rom[0] = 20'h301A5; rom[1] = 20'h70010;
    do_reset();
    pulse_start();
    hi = 0;
    first = -1;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      if (out_valid) begin
        hi++;
        if (first < 0) first = c;
      end
    end
    check("out_pulses", 32'(hi), 32'd1);
    check("out_cycle", 32'(first), 32'd6);
    check("out_data", 32'(out_data), 32'hA5);

    // illegal class at addr 3: no write, then restart clears it
    rom_clear();
    rom[0] = 20'h30111; rom[1] = 20'h00000; rom[2] = 20'h00000;
    rom[3] = 20'h93456; rom[4] = 20'h30299;
    do_reset();
    wb = wr_cnt;
    pulse_start();
    wait_halt(n);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_writes", 32'(wr_cnt - wb), 32'd1);
    check("ill_r4", 32'(rf[4]), 32'h00);
    check("ill_pc", 32'(imem_addr), 32'h04);
    pulse_start();
    check("ill_clr", 32'(illegal), 32'd0);
    check("ill_restart_pc", 32'(imem_addr), 32'h00);
    check("ill_restart_busy", 32'(busy), 32'd1);

    // reset during EXEC of LDI
    rom_clear();
    rom[0] = 20'h30977;
    do_reset();
    pulse_start();
    tick(2);
    check("rx_we_before", 32'(write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rx_we_drop", 32'(write_en), 32'd0);
    check("rx_busy", 32'(busy), 32'd0);
    tick(1);
    check("rx_no_write", 32'(rf[9]), 32'h00);
    check("rx_idle", 32'({busy, halted}), 32'd0);
    rst_n = 1'b1;

    // pc wrap 0xFF -> 0x00
    rom_clear();
    rom[0] = 20'h400FF; rom[255] = 20'h00000;
    do_reset();
    pulse_start();
    tick(3);
    check("wrap_ff", 32'(imem_addr), 32'hFF);
    tick(3);
    check("wrap_00", 32'(imem_addr), 32'h00);

`ifdef DP_SEQ_SINGLE_STEP_EN
    rom_clear();
    rom[0] = 20'h30101; rom[1] = 20'h30202;
    do_reset();
    step_mode = 1'b1;
    pulse_start();
    tick(3);
    check("st_r1", 32'(rf[1]), 32'h01);
    check("st_busy", 32'(busy), 32'd1);
    tick(5);
    check("st_hold_r2", 32'(rf[2]), 32'h00);
    check("st_hold_pc", 32'(imem_addr), 32'h01);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(3);
    check("st_r2", 32'(rf[2]), 32'h02);
    tick(5);
    check("st_no_halt", 32'(halted), 32'd0);
    check("st_pc", 32'(imem_addr), 32'h02);
    step_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
